// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types for the instruction prefetch stage.
package ifetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef enum logic [1:0] {
    LO  = 2'd0,
    HI  = 2'd1,
    CAP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous queue of assembled instructions.
// flush wins over push and pop; pop on an empty queue is ignored.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rd_ptr];

  // storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !do_pop) begin
        count <= count + 1'b1;
      end else if (!push && do_pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: prefetches 16-bit instructions from a byte-wide ROM (low byte
// at the even address) into a small queue feeding the core. A redirect
// flushes the queue and restarts fetch at the jump target.
// Optional: define IFETCH_PERF_EN to add StallCnt/FlushCnt counters.
//
// state | meaning
// LO    | idle; start a low-byte read once the queue has room
// HI    | low byte arriving; capture it and request the high byte
// CAP   | high byte arriving; push the instruction, chain the next read if room
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              ADDR_W   = 12,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               Clk,
  input  logic               Rst,
  output logic [ADDR_W-1:0]  RomAddr,
  output logic               RomRd,
  input  logic [7:0]         RomData,
  input  logic               Redirect,
  input  logic [PC_W-1:0]    RedirectPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  output logic [INSTR_W-1:0] Instr,
  output logic [PC_W-1:0]    InstrPC
`ifdef IFETCH_PERF_EN
  ,
  output logic [15:0]        StallCnt,
  output logic [15:0]        FlushCnt
`endif
);

  localparam int              CNT_W     = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);
  localparam logic [PC_W-1:0] RESET_FPC = {RESET_PC[PC_W-1:1], 1'b0};

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [PC_W-1:0]  fpc;
  logic [PC_W-1:0]  ipc;
  logic [PC_W-1:0]  next_pc;
  logic [PC_W-1:0]  lo_pc;
  logic [7:0]       lo_byte;
  logic [CNT_W-1:0] count;
  logic             empty;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic             pop;
  logic             push;
  logic             room_lo;
  logic             room_cap;
  logic             issue_lo;
  logic             issue_hi;
  logic             lo_capture;
  logic             unused_bits;

  // Jump targets are halfword aligned; the low bit is dropped on purpose.
  assign unused_bits = RedirectPC[0];

  assign pop        = InstrValid && InstrReady;
  assign next_pc    = ipc + 16'd2;
  assign push_entry = {ipc, RomData, lo_byte};

  // In LO nothing is in flight, so the occupancy alone decides. In CAP the
  // pending push lands this cycle, so a simultaneous pop frees its slot.
  assign room_lo  = (count < DEPTH_C);
  assign room_cap = pop || (count < DEPTH_M1);

  assign InstrValid = !empty;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (Clk),
    .rst_b      (Rst),
    .push       (push),
    .pop        (pop),
    .flush      (Redirect),
    .push_entry (push_entry),
    .count      (count),
    .head       (head),
    .empty      (empty)
  );

  // state register
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= LO;
    end else begin
      state <= state_next;
    end
  end

  // next-state logic; a redirect always returns to LO
  always_comb begin
    state_next = state;
    if (Redirect) begin
      state_next = LO;
    end else begin
      case (state)
        LO:      if (room_lo) state_next = HI;
        HI:      state_next = CAP;
        CAP:     state_next = room_cap ? HI : LO;
        default: state_next = LO;
      endcase
    end
  end

  // per-state fetch actions
  always_comb begin
    issue_lo   = 1'b0;
    issue_hi   = 1'b0;
    lo_capture = 1'b0;
    push       = 1'b0;
    lo_pc      = fpc;
    if (!Redirect) begin
      case (state)
        LO: begin
          issue_lo = room_lo;
        end
        HI: begin
          lo_capture = 1'b1;
          issue_hi   = 1'b1;
        end
        CAP: begin
          push     = 1'b1;
          issue_lo = room_cap;
          lo_pc    = next_pc;
        end
        default: ;
      endcase
    end
  end

  // ROM request and fetch-address registers
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      RomRd   <= 1'b0;
      RomAddr <= '0;
      fpc     <= RESET_FPC;
      ipc     <= '0;
      lo_byte <= '0;
    end else if (Redirect) begin
      RomRd <= 1'b0;
      fpc   <= {RedirectPC[PC_W-1:1], 1'b0};
    end else begin
      RomRd <= issue_lo || issue_hi;
      if (lo_capture) begin
        lo_byte <= RomData;
      end
      if (push) begin
        fpc <= next_pc;
      end
      if (issue_lo) begin
        ipc     <= lo_pc;
        RomAddr <= lo_pc[ADDR_W-1:0];
      end else if (issue_hi) begin
        RomAddr <= {ipc[ADDR_W-1:1], 1'b1};
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;

  // saturating stall and flush counters
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (InstrReady && !InstrValid && !Redirect && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (Redirect && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
